instr_sequencer: RTL and testbench
==================================

# instr_sequencer

Parametrised multi-cycle control sequencer for the 9-bit RISC core. It accepts one instruction at a time from fetch over a valid/ready handshake and decodes the 3-bit opcode (AND, ADD, XOR, LSH, LDI, LDM, STR, BNE). It drives the ALU, register-file, memory and PC-select controls through a small Moore FSM, waiting on a memory-done handshake for loads and stores. It sits between instruction fetch and the datapath, and generalises the fixed 9-bit opcode map to configurable instruction, opcode and register-field widths.

## Interface
Parameters:
- INSTR_W, 9, instruction width.
- OP_W, 3, opcode field width (MSBs); opcodes 0..7 map AND, ADD, XOR, LSH, LDI, LDM, STR, BNE; values ≥8 (OP_W>3) are NOPs.
- REG_W, 3, rs/rt field width; INSTR_W-OP_W must equal 2*REG_W (elaboration error otherwise).
- MEM_TIMEOUT, 15, max MEM-state cycles before abort (only with timeout enabled).
- CNT_W, 16, retire-counter width.

Ports:
- Clk in 1: single clock, rising edge.
- Reset in 1: asynchronous, active-high.
- instr in INSTR_W: instruction from fetch.
- instr_valid in 1 / instr_ready out 1: fetch handshake.
- eq_flag in 1: ALU rs==rt result, sampled in EXEC.
- mem_done in 1: memory access complete.
- alu_op out OP_W: latched opcode.
- rs, rt out REG_W: register fields, instr[INSTR_W-OP_W-1 -: REG_W], instr[REG_W-1:0].
- imm out INSTR_W-OP_W: instr[INSTR_W-OP_W-1:0].
- reg_we, mem_re, mem_we, pc_sel out 1: datapath controls.
- instr_done out 1: one-cycle retire pulse.
- err out 1: sticky memory-timeout flag.
- retire_cnt out CNT_W: retired-instruction count.

## Operation
- States: IDLE, EXEC, MEM, WB.
- IDLE: instr_ready=1. On instr_valid, latch instr and go to EXEC. Otherwise stay.
- EXEC (one cycle): rs/rt/imm/alu_op are valid from EXEC until the next accept.
  - AND/ADD/XOR/LSH/LDI: reg_we=1, instr_done=1, go to IDLE.
  - BNE: pc_sel=~eq_flag, instr_done=1, go to IDLE.
  - LDM/STR: go to MEM.
  - Opcode ≥8: instr_done=1 only, go to IDLE.
- MEM: mem_re=1 (LDM) or mem_we=1 (STR), held every MEM cycle. On mem_done go to WB.
- WB (one cycle): reg_we=1 for LDM only, instr_done=1, go to IDLE.
- All controls are Moore-decoded from state and the latched instruction. There is no combinational input-to-output path, except that pc_sel follows eq_flag during EXEC.
- retire_cnt increments on every instr_done and wraps at 2^CNT_W-1 → 0.
- err is set on timeout and is cleared only by Reset.

## Timing
- Reset (async, immediate): state IDLE, latched instr 0, all outputs 0 except instr_ready=1, retire_cnt 0, err 0, timeout counter 0. A Reset during MEM/WB aborts the access with no reg_we or instr_done.
- Accept-to-retire latency:
  - ALU/LDI/BNE: 1 cycle (EXEC follows accept).
  - LDM/STR: 2 + N cycles, where N = MEM cycles up to and including the mem_done cycle.
- Peak throughput is one instruction per 2 cycles; instr_ready=0 outside IDLE.
- mem_done is ignored outside MEM. If mem_done is high on the first MEM cycle, WB follows immediately.
- instr_done and the retire_cnt increment occur in the same cycle; retire_cnt reflects the increment on the next edge.

## Configuration
- SEQ_MEM_TIMEOUT_EN defined: a counter of width $clog2(MEM_TIMEOUT+1) runs in MEM.
  - If MEM_TIMEOUT cycles elapse without mem_done, set err, deassert mem_re/mem_we, go to IDLE with no reg_we, no instr_done and no retire count.
  - mem_done on the MEM_TIMEOUT-th cycle wins over the timeout.
- SEQ_MEM_TIMEOUT_EN undefined: MEM waits indefinitely, err is tied to 0, and no counter is present.

## Test plan
- ADD: reset, then instr=9'b001_010_011 with valid → EXEC cycle shows alu_op=1, rs=2, rt=3, reg_we=1, instr_done=1; retire_cnt=1.
- LDI: instr=9'b100_101010 → imm=42, reg_we=1 in EXEC. BNE with eq_flag=0 → pc_sel=1; with eq_flag=1 → pc_sel=0.
- LDM: mem_done after 3 MEM cycles → mem_re high for exactly 3 cycles, then WB with reg_we=1; accept-to-done latency 5. STR with the same stimulus gives reg_we=0 throughout.
- Timeout (macro on, MEM_TIMEOUT=4): LDM with mem_done held low → err=1 after 4 MEM cycles, back in IDLE, retire_cnt unchanged. Macro off: FSM stays in MEM for 100 cycles with err=0.
- Reset asserted mid-MEM: all outputs reset immediately (not at the next edge), instr_ready=1, retire_cnt=0. A following ADD retires normally.
- Wrap: CNT_W=4, retire 17 ALU instructions → retire_cnt=1.

Source files
------------

// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle Moore control sequencer for the RISC core.
// It accepts one instruction from fetch, decodes the opcode, and steps
// through IDLE -> EXEC -> (MEM -> WB) to drive the ALU, register-file,
// memory and PC-select controls.
// Optional feature: define SEQ_MEM_TIMEOUT_EN to abort memory accesses
// that wait longer than MEM_TIMEOUT cycles and raise the sticky err flag.
module instr_sequencer #(
  parameter int INSTR_W     = 9,
  parameter int OP_W        = 3,
  parameter int REG_W       = 3,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [INSTR_W-1:0]       instr,
  input  logic                     instr_valid,
  output logic                     instr_ready,
  input  logic                     eq_flag,
  input  logic                     mem_done,
  output logic [OP_W-1:0]          alu_op,
  output logic [REG_W-1:0]         rs,
  output logic [REG_W-1:0]         rt,
  output logic [INSTR_W-OP_W-1:0]  imm,
  output logic                     reg_we,
  output logic                     mem_re,
  output logic                     mem_we,
  output logic                     pc_sel,
  output logic                     instr_done,
  output logic                     err,
  output logic [CNT_W-1:0]         retire_cnt
);

  // The operand fields must exactly fill the bits below the opcode.
  if (INSTR_W - OP_W != 2 * REG_W) begin : g_bad_fields
    $error("instr_sequencer: INSTR_W-OP_W must equal 2*REG_W");
  end
  if (MEM_TIMEOUT < 1) begin : g_bad_timeout
    $error("instr_sequencer: MEM_TIMEOUT must be at least 1");
  end

  localparam logic [OP_W-1:0] OP_LDI = OP_W'(4);
  localparam logic [OP_W-1:0] OP_LDM = OP_W'(5);
  localparam logic [OP_W-1:0] OP_STR = OP_W'(6);
  localparam logic [OP_W-1:0] OP_BNE = OP_W'(7);

  typedef enum logic [1:0] {IDLE, EXEC, MEM, WB} state_t;

  state_t               state;
  state_t               next_state;
  logic [INSTR_W-1:0]   instr_q;
  logic [OP_W-1:0]      op;
  logic                 is_alu;
  logic                 is_ldm;
  logic                 is_str;
  logic                 is_bne;
  logic                 timeout;

  assign op     = instr_q[INSTR_W-1 -: OP_W];
  assign is_alu = (op <= OP_LDI);
  assign is_ldm = (op == OP_LDM);
  assign is_str = (op == OP_STR);
  assign is_bne = (op == OP_BNE);

  assign alu_op = op;
  assign rs     = instr_q[INSTR_W-OP_W-1 -: REG_W];
  assign rt     = instr_q[REG_W-1:0];
  assign imm    = instr_q[INSTR_W-OP_W-1:0];

`ifdef SEQ_MEM_TIMEOUT_EN
  localparam int TW = $clog2(MEM_TIMEOUT + 1);
  logic [TW-1:0] mem_cnt;

  // Abort when the last allowed MEM cycle ends without mem_done.
  assign timeout = (state == MEM) && !mem_done && (mem_cnt == TW'(MEM_TIMEOUT - 1));

  // Count cycles spent in MEM; cleared whenever the FSM is elsewhere.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mem_cnt <= '0;
    else if (state == MEM && next_state == MEM) mem_cnt <= mem_cnt + TW'(1);
    else mem_cnt <= '0;
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err <= 1'b0;
    else if (timeout) err <= 1'b1;
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= next_state;
  end

  // Capture the instruction on handshake acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) instr_q <= '0;
    else if (state == IDLE && instr_valid) instr_q <= instr;
  end

  // Count retired instructions, wrapping naturally at the counter width.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) retire_cnt <= '0;
    else if (instr_done) retire_cnt <= retire_cnt + CNT_W'(1);
  end

  // Next-state decode.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (instr_valid) next_state = EXEC;
      EXEC: next_state = (is_ldm || is_str) ? MEM : IDLE;
      MEM: begin
        if (mem_done) next_state = WB;
        else if (timeout) next_state = IDLE;
      end
      WB: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Moore output decode from state and latched opcode; only pc_sel
  // passes eq_flag straight through during EXEC.
  always_comb begin
    instr_ready = 1'b0;
    reg_we      = 1'b0;
    mem_re      = 1'b0;
    mem_we      = 1'b0;
    pc_sel      = 1'b0;
    instr_done  = 1'b0;
    case (state)
      IDLE: instr_ready = 1'b1;
      EXEC: begin
        if (is_alu) begin
          reg_we     = 1'b1;
          instr_done = 1'b1;
        end else if (is_bne) begin
          pc_sel     = ~eq_flag;
          instr_done = 1'b1;
        end else if (!is_ldm && !is_str) begin
          instr_done = 1'b1;
        end
      end
      MEM: begin
        mem_re = is_ldm;
        mem_we = is_str;
      end
      WB: begin
        reg_we     = is_ldm;
        instr_done = 1'b1;
      end
      default: instr_ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: directed bench for instr_sequencer with a
// transaction-level reference model compared against the DUT every cycle.
// Built with SEQ_MEM_TIMEOUT_EN it exercises the timeout path instead of
// the indefinite memory wait.
module tb_instr_sequencer;

  localparam int TO = 4;
`ifdef SEQ_MEM_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [8:0] instr = '0;
  logic       instrValid = 1'b0;
  logic       eqFlag = 1'b0;
  logic       memDone = 1'b0;
  logic       instrReady;
  logic [2:0] aluOp;
  logic [2:0] rs;
  logic [2:0] rt;
  logic [5:0] imm;
  logic       regWe;
  logic       memRe;
  logic       memWe;
  logic       pcSel;
  logic       instrDone;
  logic       err;
  logic [3:0] retireCnt;

  int checks = 0;
  int errors = 0;
  bit compareOn = 1'b0;

  instr_sequencer #(
    .INSTR_W(9), .OP_W(3), .REG_W(3), .MEM_TIMEOUT(TO), .CNT_W(4)
  ) dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instrValid),
    .instr_ready(instrReady), .eq_flag(eqFlag), .mem_done(memDone),
    .alu_op(aluOp), .rs(rs), .rt(rt), .imm(imm), .reg_we(regWe),
    .mem_re(memRe), .mem_we(memWe), .pc_sel(pcSel), .instr_done(instrDone),
    .err(err), .retire_cnt(retireCnt)
  );

  always #5 clk = ~clk;

  // Model state: whether an instruction is in flight, how many cycles since
  // it was accepted, and at which age its memory access completed.
  bit         mBusy = 1'b0;
  int         mAge = 0;
  int         mDoneAge = 0;
  logic [8:0] mInstr = '0;
  bit         mErr = 1'b0;
  int         mCnt = 0;

  int  expOp;
  bit  phaseExec, phaseMem, phaseWb;
  bit  expReady, expRegWe, expDone, expPc, expRe, expWe;

  // Expected controls from the instruction's position in its lifetime.
  always_comb begin
    expOp     = int'(mInstr[8:6]);
    phaseExec = mBusy && (mAge == 1);
    phaseWb   = mBusy && (mDoneAge != 0);
    phaseMem  = mBusy && (mAge >= 2) && (mDoneAge == 0);
    expReady  = !mBusy;
    expRegWe  = (phaseExec && expOp <= 4) || (phaseWb && expOp == 5);
    expDone   = (phaseExec && expOp != 5 && expOp != 6) || phaseWb;
    expPc     = phaseExec && (expOp == 7) && !eqFlag;
    expRe     = phaseMem && (expOp == 5);
    expWe     = phaseMem && (expOp == 6);
  end

  // Advance the model on each clock; reset clears it immediately.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mBusy <= 1'b0; mAge <= 0; mDoneAge <= 0; mInstr <= '0; mErr <= 1'b0; mCnt <= 0;
    end else if (!mBusy) begin
      if (instrValid) begin
        mBusy <= 1'b1; mAge <= 1; mDoneAge <= 0; mInstr <= instr;
      end
    end else if (expDone) begin
      mBusy <= 1'b0;
      mCnt  <= (mCnt + 1) % 16;
    end else begin
      if (phaseMem) begin
        if (memDone) mDoneAge <= mAge;
        else if (TIMEOUT_ON && (mAge - 1 == TO)) begin
          mErr  <= 1'b1;
          mBusy <= 1'b0;
        end
      end
      mAge <= mAge + 1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every DUT output against the model mid-cycle.
  always @(negedge clk) begin
    if (compareOn) begin
      checkOutput("m_ready", instrReady, expReady);
      checkOutput("m_reg_we", regWe, expRegWe);
      checkOutput("m_mem_re", memRe, expRe);
      checkOutput("m_mem_we", memWe, expWe);
      checkOutput("m_pc_sel", pcSel, expPc);
      checkOutput("m_done", instrDone, expDone);
      checkOutput("m_err", err, mErr);
      checkOutput("m_cnt", retireCnt, mCnt);
      checkOutput("m_alu_op", aluOp, mInstr[8:6]);
      checkOutput("m_rs", rs, mInstr[5:3]);
      checkOutput("m_rt", rt, mInstr[2:0]);
      checkOutput("m_imm", imm, mInstr[5:0]);
    end
  end

  task automatic nextCycle;
    @(posedge clk);
    #1;
  endtask

  // Present one instruction and return one step after the accepting edge.
  task automatic applyStimulus(input logic [8:0] ins);
    instr = ins;
    instrValid = 1'b1;
    nextCycle();
    instrValid = 1'b0;
  endtask

  // Issue a memory instruction, raise mem_done at sample doneAt, and tally
  // controls until retire, return to idle, or the cycle budget runs out.
  task automatic runMem(input logic [8:0] ins, input int doneAt, input int maxCycles,
                        output int lat, output int re, output int we, output int rwe);
    lat = 0; re = 0; we = 0; rwe = 0;
    applyStimulus(ins);
    for (int k = 1; k <= maxCycles; k++) begin
      if (k > 1 && instrReady) break;
      re  += int'(memRe);
      we  += int'(memWe);
      rwe += int'(regWe);
      if (instrDone) begin
        lat = k;
        memDone = 1'b0;
        nextCycle();
        break;
      end
      memDone = (k == doneAt);
      nextCycle();
    end
    memDone = 1'b0;
  endtask

  int lat, re, we, rwe;

  // Directed sequence with hand-computed expectations.
  initial begin
    compareOn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_ready", instrReady, 1);
    checkOutput("rst_cnt", retireCnt, 0);
    checkOutput("rst_reg_we", regWe, 0);
    rst = 1'b0;
    nextCycle();

    applyStimulus(9'b001_010_011);
    checkOutput("add_op", aluOp, 1);
    checkOutput("add_rs", rs, 2);
    checkOutput("add_rt", rt, 3);
    checkOutput("add_reg_we", regWe, 1);
    checkOutput("add_done", instrDone, 1);
    checkOutput("add_ready", instrReady, 0);
    nextCycle();
    checkOutput("add_cnt", retireCnt, 1);

    applyStimulus(9'b100_101010);
    checkOutput("ldi_imm", imm, 42);
    checkOutput("ldi_reg_we", regWe, 1);
    nextCycle();

    eqFlag = 1'b0;
    applyStimulus(9'b111_001_010);
    checkOutput("bne_ne_pc", pcSel, 1);
    checkOutput("bne_ne_done", instrDone, 1);
    nextCycle();
    eqFlag = 1'b1;
    applyStimulus(9'b111_001_001);
    checkOutput("bne_eq_pc", pcSel, 0);
    eqFlag = 1'b0;
    #1;
    checkOutput("bne_follow_pc", pcSel, 1);
    nextCycle();

    runMem(9'b101_001_010, 4, 20, lat, re, we, rwe);
    checkOutput("ldm_latency", lat, 5);
    checkOutput("ldm_re_cycles", re, 3);
    checkOutput("ldm_we_cycles", we, 0);
    checkOutput("ldm_reg_we", rwe, 1);

    runMem(9'b110_011_100, 4, 20, lat, re, we, rwe);
    checkOutput("str_latency", lat, 5);
    checkOutput("str_we_cycles", we, 3);
    checkOutput("str_re_cycles", re, 0);
    checkOutput("str_reg_we", rwe, 0);
    checkOutput("mem_cnt", retireCnt, 6);

`ifdef SEQ_MEM_TIMEOUT_EN
    runMem(9'b101_000_001, 0, 20, lat, re, we, rwe);
    checkOutput("to_re_cycles", re, TO);
    checkOutput("to_latency", lat, 0);
    checkOutput("to_err", err, 1);
    checkOutput("to_ready", instrReady, 1);
    checkOutput("to_cnt", retireCnt, 6);
`else
    runMem(9'b101_000_001, 0, 101, lat, re, we, rwe);
    checkOutput("wait_re_cycles", re, 100);
    checkOutput("wait_err", err, 0);
    checkOutput("wait_ready", instrReady, 0);
    memDone = 1'b1;
    nextCycle();
    memDone = 1'b0;
    checkOutput("wait_wb_done", instrDone, 1);
    checkOutput("wait_wb_reg_we", regWe, 1);
    nextCycle();
`endif

    applyStimulus(9'b101_010_010);
    nextCycle();
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_ready", instrReady, 1);
    checkOutput("arst_mem_re", memRe, 0);
    checkOutput("arst_cnt", retireCnt, 0);
    checkOutput("arst_err", err, 0);
    checkOutput("arst_op", aluOp, 0);
    checkOutput("arst_done", instrDone, 0);
    nextCycle();
    rst = 1'b0;
    nextCycle();
    applyStimulus(9'b001_010_011);
    checkOutput("post_rst_done", instrDone, 1);
    nextCycle();
    checkOutput("post_rst_cnt", retireCnt, 1);

    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
    nextCycle();
    for (int i = 0; i < 17; i++) begin
      applyStimulus(9'b010_001_001);
      nextCycle();
    end
    checkOutput("wrap_cnt", retireCnt, 1);

    nextCycle();
    compareOn = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
